// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory request types and arbiter enums
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] mtrans_t;

  typedef struct packed {
    addr_t                 a;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    mtrans_t               d;
  } mem_req_t;

  typedef enum logic {OWNER_IF, OWNER_LS} owner_e;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-outstanding memory port arbiter
// MEM_ARB_RR_EN selects round-robin arbitration; default is fixed priority LS over IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     if_req_valid_i,
  output logic     if_req_ready_o,
  input  mem_req_t if_req_data_i,
  output logic     if_resp_valid_o,
  input  logic     if_resp_ready_i,
  output mtrans_t  if_resp_data_o,
  input  logic     ls_req_valid_i,
  output logic     ls_req_ready_o,
  input  mem_req_t ls_req_data_i,
  output logic     ls_resp_valid_o,
  input  logic     ls_resp_ready_i,
  output mtrans_t  ls_resp_data_o,
  output logic     bus_req_valid_o,
  input  logic     bus_req_ready_i,
  output mem_req_t bus_req_data_o,
  input  logic     bus_resp_valid_i,
  output logic     bus_resp_ready_o,
  input  mtrans_t  bus_resp_data_i,
  input  logic     flush_i
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   drop_q, drop_d;
`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q, last_owner_d;
`endif

  logic   if_cand, ls_cand, req_any, drop_now, resp_rdy;
  owner_e grant;

  assign if_resp_data_o   = bus_resp_data_i;
  assign ls_resp_data_o   = bus_resp_data_i;
  assign bus_resp_ready_o = resp_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_LS;
      drop_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWNER_LS;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      drop_q       <= drop_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    drop_d          = drop_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d    = last_owner_q;
`endif
    if_cand         = 1'b0;
    ls_cand         = 1'b0;
    req_any         = 1'b0;
    grant           = OWNER_IF;
    drop_now        = 1'b0;
    resp_rdy        = 1'b0;
    bus_req_valid_o = 1'b0;
    bus_req_data_o  = if_req_data_i;
    if_req_ready_o  = 1'b0;
    ls_req_ready_o  = 1'b0;
    if_resp_valid_o = 1'b0;
    ls_resp_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A flush blocks a fetch grant in the same cycle the fetch is being discarded.
        if_cand = if_req_valid_i & ~flush_i;
        ls_cand = ls_req_valid_i;
        req_any = if_cand | ls_cand;
`ifdef MEM_ARB_RR_EN
        if (if_cand && ls_cand) begin
          grant = (last_owner_q == OWNER_LS) ? OWNER_IF : OWNER_LS;
        end else begin
          grant = ls_cand ? OWNER_LS : OWNER_IF;
        end
`else
        grant = ls_cand ? OWNER_LS : OWNER_IF;
`endif
        bus_req_valid_o = req_any;
        bus_req_data_o  = (grant == OWNER_LS) ? ls_req_data_i : if_req_data_i;
        if_req_ready_o  = req_any & (grant == OWNER_IF) & bus_req_ready_i;
        ls_req_ready_o  = req_any & (grant == OWNER_LS) & bus_req_ready_i;
        if (req_any && bus_req_ready_i) begin
          state_d = ST_BUSY;
          owner_d = grant;
          drop_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
          last_owner_d = grant;
`endif
        end
      end
      default: begin
        // Flushed fetch data is swallowed: accepted from the bus, never presented.
        drop_now = drop_q | ((owner_q == OWNER_IF) & flush_i);
        if (owner_q == OWNER_IF) begin
          if_resp_valid_o = bus_resp_valid_i & ~drop_now;
          resp_rdy        = drop_now | if_resp_ready_i;
        end else begin
          ls_resp_valid_o = bus_resp_valid_i;
          resp_rdy        = ls_resp_ready_i;
        end
        drop_d = drop_now;
        if (bus_resp_valid_i && resp_rdy) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      end
    endcase

    if (rst) begin
      bus_req_valid_o = 1'b0;
      if_req_ready_o  = 1'b0;
      ls_req_ready_o  = 1'b0;
      if_resp_valid_o = 1'b0;
      ls_resp_valid_o = 1'b0;
      resp_rdy        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     if_pend, ls_pend, if_rdy, ls_rdy, bus_rdy, rsp_valid, flush;
  mem_req_t if_req, ls_req;
  mtrans_t  rsp_data;
  logic     if_req_ready_o, if_resp_valid_o, ls_req_ready_o, ls_resp_valid_o;
  logic     bus_req_valid_o, bus_resp_ready_o;
  mtrans_t  if_resp_data_o, ls_resp_data_o;
  mem_req_t bus_req_data_o;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid_i(if_pend), .if_req_ready_o(if_req_ready_o), .if_req_data_i(if_req),
    .if_resp_valid_o(if_resp_valid_o), .if_resp_ready_i(if_rdy), .if_resp_data_o(if_resp_data_o),
    .ls_req_valid_i(ls_pend), .ls_req_ready_o(ls_req_ready_o), .ls_req_data_i(ls_req),
    .ls_resp_valid_o(ls_resp_valid_o), .ls_resp_ready_i(ls_rdy), .ls_resp_data_o(ls_resp_data_o),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_rdy), .bus_req_data_o(bus_req_data_o),
    .bus_resp_valid_i(rsp_valid), .bus_resp_ready_o(bus_resp_ready_o), .bus_resp_data_i(rsp_data),
    .flush_i(flush)
  );

  int n_cmp = 0;
  int n_bad = 0;
  mtrans_t if_q[$];
  mtrans_t ls_q[$];

  // Reference model: who holds the bus (0 = fetch, 1 = load/store), last winner, flushed fetch.
  bit m_busy, m_owner, m_last, m_flushed;
  bit exp_if_vis, exp_ls_vis;
  bit if_fired, ls_fired, rsp_fired, stale;
  int rsp_wait, lat;
  int p_if, p_ls, p_flush, p_rdy, p_bus;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_chk();
    chk("rst_bus_req_valid", bus_req_valid_o, 0);
    chk("rst_bus_resp_ready", bus_resp_ready_o, 0);
    chk("rst_if_req_ready", if_req_ready_o, 0);
    chk("rst_ls_req_ready", ls_req_ready_o, 0);
    chk("rst_if_resp_valid", if_resp_valid_o, 0);
    chk("rst_ls_resp_valid", ls_resp_valid_o, 0);
  endtask

  function automatic bit roll(input int pct);
    return ($urandom % 100) < pct;
  endfunction

  task automatic drive_inputs();
    logic [31:0] r;
    if (if_fired) if_pend = 1'b0;
    if (ls_fired) ls_pend = 1'b0;
    if_fired = 0;
    ls_fired = 0;
    if (!if_pend && roll(p_if)) begin
      r = $urandom;
      if_pend = 1'b1;
      if_req.a = {r[31:2], 2'b00};
      if_req.we = 1'b0;
      if_req.be = 4'hf;
      if_req.d = '0;
    end
    if (!ls_pend && roll(p_ls)) begin
      r = $urandom;
      ls_pend = 1'b1;
      ls_req.a = {r[31:2], 2'b00};
      ls_req.we = r[0];
      ls_req.be = r[5:2];
      ls_req.d = $urandom;
    end
    flush = roll(p_flush);
    if_rdy = roll(p_rdy);
    ls_rdy = roll(p_rdy);
    bus_rdy = roll(p_bus);
    if (stale) begin
      rsp_valid = 1'b1;
    end else begin
      if (rsp_fired || !m_busy) rsp_valid = 1'b0;
      rsp_fired = 0;
      if (m_busy && !rsp_valid) begin
        if (rsp_wait == 0) begin
          rsp_valid = 1'b1;
          rsp_data = $urandom;
        end else begin
          rsp_wait--;
        end
      end
    end
  endtask

  task automatic model_eval();
    bit ifc, lsc, ev, g, drop, brr;
    if (!m_busy) begin
      ifc = if_pend && !flush;
      lsc = ls_pend;
`ifdef MEM_ARB_RR_EN
      if (ifc && lsc) g = !m_last;
      else g = lsc;
`else
      g = lsc;
`endif
      ev = ifc || lsc;
      exp_if_vis = 0;
      exp_ls_vis = 0;
      chk("bus_req_valid", bus_req_valid_o, ev);
      if (ev) chk("bus_req_data", bus_req_data_o, g ? ls_req : if_req);
      chk("if_req_ready", if_req_ready_o, ev && !g && bus_rdy);
      chk("ls_req_ready", ls_req_ready_o, ev && g && bus_rdy);
      chk("bus_resp_ready_idle", bus_resp_ready_o, 0);
      if (ev && bus_rdy) begin
        m_busy = 1;
        m_owner = g;
        m_last = g;
        m_flushed = 0;
        if (g) ls_fired = 1;
        else if_fired = 1;
        rsp_wait = (lat < 0) ? $urandom_range(0, 4) : lat;
      end
    end else begin
      chk("bus_req_valid_busy", bus_req_valid_o, 0);
      chk("if_req_ready_busy", if_req_ready_o, 0);
      chk("ls_req_ready_busy", ls_req_ready_o, 0);
      drop = !m_owner && (m_flushed || flush);
      exp_if_vis = rsp_valid && !m_owner && !drop;
      exp_ls_vis = rsp_valid && m_owner;
      brr = drop || (m_owner ? ls_rdy : if_rdy);
      chk("bus_resp_ready", bus_resp_ready_o, brr);
      if (rsp_valid && brr) begin
        if (!drop) begin
          if (m_owner) ls_q.push_back(rsp_data);
          else if_q.push_back(rsp_data);
        end
        m_busy = 0;
        rsp_fired = 1;
      end else if (drop) begin
        m_flushed = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    model_eval();
  endtask

  task automatic phase(input int n, input int pi, input int pl, input int pf,
                       input int pr, input int pb, input int l);
    p_if = pi; p_ls = pl; p_flush = pf; p_rdy = pr; p_bus = pb; lat = l;
    repeat (n) cycle();
  endtask

  // Monitor: compares response visibility and pops expected data on each response handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("if_resp_valid", if_resp_valid_o, exp_if_vis);
      chk("ls_resp_valid", ls_resp_valid_o, exp_ls_vis);
      if (if_resp_valid_o && if_rdy) begin
        if (if_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL if_resp_unexpected: got %0h expected none", if_resp_data_o);
        end else chk("if_resp_data", if_resp_data_o, if_q.pop_front());
      end
      if (ls_resp_valid_o && ls_rdy) begin
        if (ls_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ls_resp_unexpected: got %0h expected none", ls_resp_data_o);
        end else chk("ls_resp_data", ls_resp_data_o, ls_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    if_pend = 1'b1; ls_pend = 1'b1; rsp_valid = 1'b1;
    if_rdy = 1'b1; ls_rdy = 1'b1; bus_rdy = 1'b1; flush = 1'b0;
    if_req = '0; ls_req = '0; rsp_data = '0;
    m_busy = 0; m_owner = 0; m_last = 1; m_flushed = 0;
    exp_if_vis = 0; exp_ls_vis = 0;
    if_fired = 0; ls_fired = 0; rsp_fired = 0; stale = 0; rsp_wait = 0; lat = -1;
    repeat (2) begin
      @(negedge clk);
      reset_chk();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    if_pend = 1'b0; ls_pend = 1'b0; rsp_valid = 1'b0;

    phase(40, 60, 0, 0, 100, 100, 3);
    phase(300, 90, 90, 0, 70, 70, -1);
    phase(300, 70, 50, 20, 60, 70, -1);
    phase(200, 30, 80, 0, 20, 80, -1);

    // Reset while a transaction is outstanding, then present a stale response.
    p_if = 90; p_ls = 90; p_flush = 0; p_rdy = 50; p_bus = 100; lat = 4;
    for (int k = 0; k < 200 && !m_busy; k++) cycle();
    if (!m_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout: got idle expected busy");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_pend = 1'b0; ls_pend = 1'b0;
    rsp_valid = 1'b1; rsp_data = 32'h5a5a_5a5a;
    if_fired = 0; ls_fired = 0; rsp_fired = 0;
    m_busy = 0; m_last = 1; m_flushed = 0;
    exp_if_vis = 0; exp_ls_vis = 0;
    repeat (2) begin
      @(negedge clk);
      reset_chk();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 1;
    phase(4, 0, 0, 0, 100, 100, 2);
    stale = 0;
    phase(40, 80, 0, 0, 100, 100, 2);
    phase(150, 60, 60, 10, 70, 70, -1);
    phase(40, 0, 0, 0, 100, 100, 0);

    chk("if_q_drained", if_q.size(), 0);
    chk("ls_q_drained", ls_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
